// File: rtl/dbus_arbiter_pkg.sv
// Shared definitions for the data-bus controller: bus width, I/O map,
// owner and FSM encodings, and the decoded-region record.
package dbus_arbiter_pkg;

    localparam int ISA_WIDTH = 32;

    localparam logic [31:0] IO_BASE  = 32'hFFFF_FC00;
    localparam logic [31:0] LED_ADDR = 32'hFFFF_FC60;
    localparam logic [31:0] SW_ADDR  = 32'hFFFF_FC70;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // One-hot target of an access; is_err covers unmapped I/O and
    // wrong-direction accesses to the LED/switch registers.
    typedef struct packed {
        logic is_mem;
        logic is_led;
        logic is_sw;
        logic is_err;
    } region_t;

    localparam region_t REGION_NONE = 4'b0000;

endpackage

// File: rtl/dbus_decode.sv
// Address decoder for the data bus (combinational).
// Ports:
//   addr   - byte address of the granted requester (bits [1:0] ignored)
//   we     - write enable of the granted requester
//   region - {is_mem, is_led, is_sw, is_err}; exactly one bit is set
module dbus_decode
    import dbus_arbiter_pkg::*;
#(
    parameter int                DATA_W   = ISA_WIDTH,
    parameter logic [DATA_W-1:0] IO_BASE  = dbus_arbiter_pkg::IO_BASE,
    parameter logic [DATA_W-1:0] LED_ADDR = dbus_arbiter_pkg::LED_ADDR,
    parameter logic [DATA_W-1:0] SW_ADDR  = dbus_arbiter_pkg::SW_ADDR
) (
    input  logic [DATA_W-1:0] addr,
    input  logic              we,
    output region_t           region
);

    logic in_io_s;
    logic led_hit_s;
    logic sw_hit_s;
    logic addr_lsb_unused_s;

    // Byte-lane bits play no part in word-granular decoding.
    assign addr_lsb_unused_s = ^addr[1:0];

    // Region match and direction check; LED is write-only, switches read-only.
    always_comb begin
        in_io_s   = (addr[DATA_W-1:10] == IO_BASE[DATA_W-1:10]);
        led_hit_s = (addr[DATA_W-1:2] == LED_ADDR[DATA_W-1:2]);
        sw_hit_s  = (addr[DATA_W-1:2] == SW_ADDR[DATA_W-1:2]);
        region    = REGION_NONE;
        if (!in_io_s) begin
            region.is_mem = 1'b1;
        end else if (led_hit_s && we) begin
            region.is_led = 1'b1;
        end else if (sw_hit_s && !we) begin
            region.is_sw = 1'b1;
        end else begin
            region.is_err = 1'b1;
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Data-bus controller: arbitrates CPU and UART-loader accesses onto the
// data BRAM and LED/switch I/O. Every access is IDLE (issue, target strobed
// combinationally) followed by WAIT (ack + read data), which absorbs the
// BRAM's one-cycle read latency.
// Ports:
//   c_*            CPU port (req/we/addr/wdata in, ack/rdata out), cpu_stall
//   u_*            loader port, same protocol as the CPU port
//   mem_*          BRAM enable/write/word address/data
//   led_cs, sw_cs  one-cycle I/O strobes; io_wdata / io_rdata I/O data
//   bus_err        one-cycle pulse in WAIT for an unmapped I/O access
// Configuration macro: DBUS_LOADER_PRIORITY_EN - when defined the loader
// wins every tie; otherwise ties alternate round-robin.
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int                DATA_W   = ISA_WIDTH,
    parameter int                MEM_AW   = 14,
    parameter logic [DATA_W-1:0] IO_BASE  = dbus_arbiter_pkg::IO_BASE,
    parameter logic [DATA_W-1:0] LED_ADDR = dbus_arbiter_pkg::LED_ADDR,
    parameter logic [DATA_W-1:0] SW_ADDR  = dbus_arbiter_pkg::SW_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [DATA_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    output logic              cpu_stall,
    input  logic              u_req,
    input  logic              u_we,
    input  logic [DATA_W-1:0] u_addr,
    input  logic [DATA_W-1:0] u_wdata,
    output logic              u_ack,
    output logic [DATA_W-1:0] u_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              led_cs,
    output logic              sw_cs,
    output logic [DATA_W-1:0] io_wdata,
    input  logic [15:0]       io_rdata,
    output logic              bus_err
);

    state_e            state_r;
    state_e            state_nxt_s;
    owner_e            owner_r;
    owner_e            win_s;
    logic              we_r;
    region_t           region_r;
    logic [DATA_W-1:0] io_q_r;

    logic              req_any_s;
    logic              issue_s;
    logic              ack_s;
    logic [DATA_W-1:0] w_addr_s;
    logic [DATA_W-1:0] w_wdata_s;
    logic              w_we_s;
    region_t           w_region_s;
    logic [DATA_W-1:0] rdata_s;

`ifndef DBUS_LOADER_PRIORITY_EN
    owner_e            last_r;
`endif

    assign req_any_s = c_req | u_req;
    // Outputs are gated with rst_n so nothing leaks while reset is held.
    assign issue_s   = rst_n & (state_r == ST_IDLE) & req_any_s;
    assign ack_s     = rst_n & (state_r == ST_WAIT);

    // Winner selection among simultaneous requesters.
    always_comb begin
        win_s = OWN_CPU;
`ifdef DBUS_LOADER_PRIORITY_EN
        if (u_req) begin
            win_s = OWN_LDR;
        end else begin
            win_s = OWN_CPU;
        end
`else
        if (c_req && u_req) begin
            // Tie: grant whoever was not served last.
            if (last_r == OWN_CPU) begin
                win_s = OWN_LDR;
            end else begin
                win_s = OWN_CPU;
            end
        end else if (u_req) begin
            win_s = OWN_LDR;
        end else begin
            win_s = OWN_CPU;
        end
`endif
    end

    // Steer the winner's request onto the shared decode/target path.
    always_comb begin
        w_addr_s  = c_addr;
        w_wdata_s = c_wdata;
        w_we_s    = c_we;
        if (win_s == OWN_LDR) begin
            w_addr_s  = u_addr;
            w_wdata_s = u_wdata;
            w_we_s    = u_we;
        end else begin
            w_addr_s  = c_addr;
            w_wdata_s = c_wdata;
            w_we_s    = c_we;
        end
    end

    dbus_decode #(
        .DATA_W   (DATA_W),
        .IO_BASE  (IO_BASE),
        .LED_ADDR (LED_ADDR),
        .SW_ADDR  (SW_ADDR)
    ) u_decode (
        .addr   (w_addr_s),
        .we     (w_we_s),
        .region (w_region_s)
    );

    // Next-state logic: every issued access spends exactly one cycle in WAIT.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_any_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Issue-cycle target strobes, driven in the same cycle the request is seen.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {MEM_AW{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        led_cs    = 1'b0;
        sw_cs     = 1'b0;
        io_wdata  = {DATA_W{1'b0}};
        if (issue_s) begin
            if (w_region_s.is_mem) begin
                mem_en    = 1'b1;
                mem_we    = w_we_s;
                mem_addr  = w_addr_s[MEM_AW+1:2];
                mem_wdata = w_wdata_s;
            end else begin
                mem_en    = 1'b0;
            end
            if (w_region_s.is_led) begin
                led_cs   = 1'b1;
                io_wdata = w_wdata_s;
            end else begin
                led_cs   = 1'b0;
            end
            sw_cs = w_region_s.is_sw;
        end else begin
            mem_en = 1'b0;
        end
    end

    // WAIT-cycle completion: route read data to the owner only.
    always_comb begin
        rdata_s = {DATA_W{1'b0}};
        if (we_r || region_r.is_err) begin
            rdata_s = {DATA_W{1'b0}};
        end else if (region_r.is_mem) begin
            rdata_s = mem_rdata;
        end else if (region_r.is_sw) begin
            rdata_s = io_q_r;
        end else begin
            rdata_s = {DATA_W{1'b0}};
        end
        c_ack     = ack_s & (owner_r == OWN_CPU);
        u_ack     = ack_s & (owner_r == OWN_LDR);
        c_rdata   = c_ack ? rdata_s : {DATA_W{1'b0}};
        u_rdata   = u_ack ? rdata_s : {DATA_W{1'b0}};
        bus_err   = ack_s & region_r.is_err;
        cpu_stall = rst_n & c_req & ~c_ack;
    end

    // FSM state plus the transaction context latched at issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            owner_r  <= OWN_CPU;
            we_r     <= 1'b0;
            region_r <= REGION_NONE;
            io_q_r   <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (issue_s) begin
                owner_r  <= win_s;
                we_r     <= w_we_s;
                region_r <= w_region_s;
                if (w_region_s.is_sw) begin
                    io_q_r <= {{(DATA_W-16){1'b0}}, io_rdata};
                end else begin
                    io_q_r <= io_q_r;
                end
            end else begin
                owner_r <= owner_r;
            end
        end
    end

`ifndef DBUS_LOADER_PRIORITY_EN
    // Round-robin history; starts at the loader so the CPU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= OWN_LDR;
        end else if (issue_s) begin
            last_r <= win_s;
        end else begin
            last_r <= last_r;
        end
    end
`endif

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Data-bus controller between the two data-side requesters (CPU load/store port and the UART program loader) and the shared resources (synchronous data-memory BRAM, LED and switch I/O). Decodes each address into memory or I/O space and arbitrates simultaneous requests. Sequences every access as a two-state transaction so the BRAM's one-cycle read latency is absorbed, and stalls the CPU until its access completes. It sits between the CPU core/loader and the memory/I/O blocks, replacing direct memory/I/O steering by the CPU.

## Interface
- `DATA_W`, 32: data and address width (`ISA_WIDTH`).
- `MEM_AW`, 14: BRAM word-address width.
- `IO_BASE`, 32'hFFFF_FC00: I/O region base; region is `addr[31:10] == IO_BASE[31:10]`.
- `LED_ADDR`, 32'hFFFF_FC60: LED register (write-only).
- `SW_ADDR`, 32'hFFFF_FC70: switch register (read-only).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `c_req`, `c_we` in 1: CPU request, write enable. Held until `c_ack`.
- `c_addr`, `c_wdata` in 32: CPU byte address, write data.
- `c_ack` out 1: one-cycle completion pulse.
- `c_rdata` out 32: valid when `c_ack`.
- `cpu_stall` out 1: `c_req & ~c_ack`.
- `u_req`, `u_we`, `u_addr`, `u_wdata`, `u_ack`, `u_rdata`: loader port, same rules as the CPU port.
- `mem_en`, `mem_we` out 1: BRAM enable and write.
- `mem_addr` out `MEM_AW`: `addr[MEM_AW+1:2]`.
- `mem_wdata` out 32 / `mem_rdata` in 32: BRAM data; `mem_rdata` is valid the cycle after `mem_en`.
- `led_cs` out 1: one-cycle LED write strobe.
- `sw_cs` out 1: one-cycle switch read strobe.
- `io_wdata` out 32: I/O write data.
- `io_rdata` in 16: switch value.
- `bus_err` out 1: one-cycle pulse on an unmapped I/O access.

## Operation
- **FSM states.** IDLE and WAIT.
- **IDLE, no request.** All strobes are 0.
- **IDLE, request present.**
  - Select the winner.
  - Latch the owner, `we`, and the region.
  - Drive the target combinationally in the same cycle: `mem_en`/`mem_we`/`mem_addr`/`mem_wdata`, or `led_cs`/`io_wdata`, or `sw_cs`.
  - Go to WAIT.
- **Switch reads.** On the issue edge, register `{16'b0, io_rdata}` into `io_q`.
- **WAIT.**
  - Pulse the owner's `ack`.
  - Owner's `rdata` is `mem_rdata` (memory read), `io_q` (switch read), or 0 (any write or error).
  - Return to IDLE.
  - The next request is sampled in the following cycle; a requester may not re-request in the same cycle it receives `ack`.
- **Arbitration.** Round-robin via register `last`.
  - On a tie, grant the requester not in `last`.
  - `last` updates on every grant.
  - A single requester is always granted.
- **Unmapped I/O.** Any I/O-region address other than `LED_ADDR`/`SW_ADDR`, or a write to `SW_ADDR`, or a read of `LED_ADDR`:
  - no strobe is driven;
  - the transaction still completes with `rdata = 0`;
  - `bus_err` pulses in WAIT.
- **Addresses outside the I/O region** go to memory. `addr[1:0]` is ignored (word access only).
- **Non-owner signals.** The non-owner's `ack` is 0; all `rdata` outputs read 0 when not acked.

## Timing
- Request seen in IDLE at cycle T → target strobe at T, `ack` and `rdata` at T+1.
- Minimum spacing between transactions is 2 cycles.
- `cpu_stall` is high at T and low at T+1.
- Request inputs must be stable from T until `ack`. A request dropped while in WAIT is still completed.
- **Reset values.** State IDLE, `last` = loader (CPU wins the first tie), `io_q` = 0. All outputs are 0 and stay 0 while `rst_n` is low.
- **Reset asserted in WAIT.** The transaction is abandoned: no `ack` and no `bus_err` after release.

## Configuration
- `DBUS_LOADER_PRIORITY_EN`
  - Defined: the loader has fixed priority on every tie, and `last` is unused.
  - Undefined: round-robin as above.

## Structure
- **Shared package/`definitions.v`:**
  - `ISA_WIDTH`
  - `IO_BASE`, `LED_ADDR`, `SW_ADDR` constants
  - owner encoding `OWN_CPU`/`OWN_LDR`
  - state encoding `ST_IDLE`/`ST_WAIT`
- **Sub-module `dbus_decode`:** combinational; address → `{is_mem, is_led, is_sw, is_err}` (including the direction checks). Instantiated once, on the winner's address.

## Test plan
1. CPU write `0x0000_0010` data `0xDEADBEEF`, then read the same address → `mem_we=1`, `mem_addr=4` at T; `c_ack` at T+1; read returns `0xDEADBEEF` at its own T+1.
2. CPU read `0xFFFF_FC70` with `io_rdata=16'h00A5` → `sw_cs` pulse at T; `c_rdata=0x0000_00A5` with `c_ack` at T+1; `cpu_stall` high for exactly 1 cycle.
3. `c_req` and `u_req` both asserted after reset, held → CPU acked first, loader second; with `DBUS_LOADER_PRIORITY_EN`, loader first.
4. Loader write `0xFFFF_FC60` data `0x0000_00FF` → `led_cs=1`, `io_wdata=0xFF` at T; `u_ack` at T+1; no memory strobe.
5. CPU read `0xFFFF_FC80` → no strobe; `c_ack` with `c_rdata=0` and `bus_err` pulse at T+1.
6. `rst_n` driven low during WAIT of a memory read → no `c_ack`; all outputs 0; first tie after release grants the CPU.
